// File: rtl/test_pkg.sv
// Shared constants and types for the two-stage sum/difference pipeline.
package test_pkg;

    localparam int WIDTH_DEF = 16;

    typedef logic [WIDTH_DEF-1:0] word_t;

    typedef enum logic {
        STAGE_ADD = 1'b0,
        STAGE_SUB = 1'b1
    } stage_mode_e;

endpackage

// File: rtl/test_if.sv
// Sample-stream bundle: enable and input word toward the block, both stage results back.
interface test_if
    import test_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);

    logic             en;
    logic [WIDTH-1:0] inp;
    logic [WIDTH-1:0] outp_midi;
    logic [WIDTH-1:0] outp;

    modport master (
        output en,
        output inp,
        input  outp_midi,
        input  outp
    );

    modport slave (
        input  en,
        input  inp,
        output outp_midi,
        output outp
    );

endinterface

// File: rtl/test_stage.sv
// One pipeline stage: remembers the last accepted word and registers word +/- history.
module test_stage
    import test_pkg::*;
#(
    parameter int          WIDTH = WIDTH_DEF,
    parameter stage_mode_e MODE  = STAGE_ADD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] hist;
    logic [WIDTH-1:0] res;

    // Modulo 2^WIDTH by truncation; carries and borrows are dropped.
    always_comb begin
        if (MODE == STAGE_ADD) begin
            res = d + hist;
        end else begin
            res = d - hist;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
            q    <= '0;
        end else if (en) begin
            hist <= d;
            q    <= res;
        end
    end

endmodule

// File: rtl/test.sv
// Two-stage pipeline: stage 1 sums adjacent accepted samples, stage 2 differences adjacent sums.
module test
    import test_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic clk,
    input  logic rst_n,
    test_if.slave bus
);

    logic [WIDTH-1:0] midi;
    logic [WIDTH-1:0] diff;

    test_stage #(
        .WIDTH (WIDTH),
        .MODE  (STAGE_ADD)
    ) u_stage_add (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.en),
        .d     (bus.inp),
        .q     (midi)
    );

    // Stage 2 shares the enable, so its history is the previous stage-1 result.
    test_stage #(
        .WIDTH (WIDTH),
        .MODE  (STAGE_SUB)
    ) u_stage_sub (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.en),
        .d     (midi),
        .q     (diff)
    );

    assign bus.outp_midi = midi;
    assign bus.outp      = diff;

endmodule

// File: tb/tb_test.sv
// Self-checking bench: behavioural model compared every cycle plus literal expectations.
module tb_test;
    import test_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic cmp_on;

    test_if #(.WIDTH(16)) bus ();

    test #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: history of accepted samples and of stage-1 sums, kept as plain lists.
    word_t acc_q[$];
    word_t sum_q[$];
    word_t mdl_midi;
    word_t mdl_outp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q.delete();
            sum_q.delete();
            mdl_midi = '0;
            mdl_outp = '0;
        end else if (bus.en === 1'b1) begin
            word_t prev_x;
            word_t prev_s;
            word_t new_sum;
            prev_x  = (acc_q.size() > 0) ? acc_q[$] : word_t'(0);
            prev_s  = (sum_q.size() > 1) ? sum_q[$-1] : word_t'(0);
            new_sum = word_t'(bus.inp + prev_x);
            mdl_outp = word_t'(mdl_midi - prev_s);
            acc_q.push_back(bus.inp);
            sum_q.push_back(new_sum);
            mdl_midi = new_sum;
            if (acc_q.size() > 4) void'(acc_q.pop_front());
            if (sum_q.size() > 4) void'(sum_q.pop_front());
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on && rst_n) begin
            chk("model_midi", bus.outp_midi, mdl_midi);
            chk("model_outp", bus.outp, mdl_outp);
        end
    end

    task automatic cyc(input logic e, input logic [15:0] i);
        bus.en  = e;
        bus.inp = i;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.en = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int exp_midi1[5] = '{100, 201, 203, 205, 207};
    int exp_outp1[5] = '{0, 100, 101, 2, 2};
    int exp_midi2[4] = '{209, 201, 203, 205};
    int exp_outp2[4] = '{2, 65528, 65528, 2};

    initial begin
        checks  = 0;
        errors  = 0;
        cmp_on  = 1'b0;
        rst_n   = 1'b0;
        bus.en  = 1'b0;
        bus.inp = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cmp_on = 1'b1;
        chk("reset_midi", bus.outp_midi, 16'd0);
        chk("reset_outp", bus.outp, 16'd0);

        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 16'(100 + k));
            chk("burst1_midi", bus.outp_midi, 16'(exp_midi1[k]));
            chk("burst1_outp", bus.outp, 16'(exp_outp1[k]));
        end
        for (int k = 5; k < 10; k++) cyc(1'b1, 16'(100 + k));
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 16'hxxxx);
            chk("gap_midi", bus.outp_midi, 16'd217);
            chk("gap_outp", bus.outp, 16'd2);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 16'(100 + k));
            chk("burst2_midi", bus.outp_midi, 16'(exp_midi2[k]));
            chk("burst2_outp", bus.outp, 16'(exp_outp2[k]));
        end

        do_reset();
        cyc(1'b1, 16'hFFFF);
        chk("wrap_midi0", bus.outp_midi, 16'hFFFF);
        cyc(1'b1, 16'hFFFF);
        chk("wrap_midi1", bus.outp_midi, 16'hFFFE);

        // Asynchronous reset between edges, observed before any clock edge.
        cyc(1'b1, 16'd300);
        cyc(1'b1, 16'd400);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_midi", bus.outp_midi, 16'd0);
        chk("async_rst_outp", bus.outp, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 16'd50);
        chk("post_rst_midi", bus.outp_midi, 16'd50);
        chk("post_rst_outp", bus.outp, 16'd0);

        do_reset();
        cyc(1'b1, 16'd10);
        cyc(1'b0, 16'd999);
        cyc(1'b1, 16'd20);
        chk("toggle_midi_a", bus.outp_midi, 16'd30);
        cyc(1'b0, 16'd7);
        cyc(1'b1, 16'd5);
        chk("toggle_midi_b", bus.outp_midi, 16'd25);
        chk("toggle_outp_b", bus.outp, 16'd20);

        for (int k = 0; k < 400; k++) begin
            logic e;
            e = ($urandom_range(0, 2) != 0);
            if (!e && $urandom_range(0, 3) == 0) cyc(1'b0, 16'hxxxx);
            else cyc(e, 16'($urandom));
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/test.md
TEST -- requirements
Module: test

Interface
REQ-001 Parameter WIDTH, default 16, data width of inp, outp_midi and outp.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  sample-enable; high means inp is accepted at this rising edge.
REQ-005 inp  input  WIDTH  unsigned input sample stream.
REQ-006 outp_midi  output  WIDTH  registered stage-1 result: sum of the current and previous accepted samples.
REQ-007 outp  output  WIDTH  registered stage-2 result: difference of the current and previous stage-1 values.

Function
REQ-008 Internal registers: x1 (last accepted sample) and m1 (previous outp_midi), each WIDTH bits.
REQ-009 Edge with en=1: outp_midi <= inp + x1; x1 <= inp; outp <= outp_midi - m1; m1 <= outp_midi, all using pre-edge register values.
REQ-010 Edge with en=0: outp_midi, outp, x1 and m1 hold their values.
REQ-011 Arithmetic is modulo 2^WIDTH, unsigned, with no saturation and no carry/borrow output.
REQ-012 Latency: inp reaches outp_midi 1 accepted edge later and reaches outp 2 accepted edges later; en gaps stretch the latency but do not flush the pipeline.
REQ-013 History persists across en gaps, so the first sample of a new burst combines with the last sample of the previous burst.
REQ-014 Outputs are driven directly from registers, with no combinational path from inp or en to any output.
REQ-015 X or Z on inp while en=0 does not affect any register.

Reset
REQ-016 rst_n=0 asynchronously clears outp_midi, outp, x1 and m1 to 0, without waiting for a clock edge.
REQ-017 Reset asserted mid-burst discards all history; the first accepted sample after release sees x1=0 and m1=0.
REQ-018 Deassertion of rst_n is synchronised by the integrator; the block is only required to behave correctly from the first rising edge after release.

Structure
REQ-019 A shared package test_pkg holds the WIDTH default constant and the data word typedef.
REQ-020 One sub-module test_stage (enable-gated register pair plus adder/subtractor, mode parameter ADD/SUB) is instantiated twice, as stage 1 (ADD) and stage 2 (SUB).
REQ-021 Top level contains only the two stage instances and port wiring; no FSM is required.

Verification
REQ-022 Reset, then en=1 with inp=100,101,102,103,104 on consecutive edges -> outp_midi=100,201,203,205,207 and outp=0,100,101,2,2.
REQ-023 Continue inp=105..109, then en=0 for 4 cycles -> outp_midi=217 and outp=2 held constant during the gap.
REQ-024 Second burst inp=100,101,102,103 with en=1 -> outp_midi=209,201,203,205 and outp=2,65528,65528,2.
REQ-025 Two accepted samples 16'hFFFF, 16'hFFFF after reset -> outp_midi=16'hFFFF then 16'hFFFE (wrap).
REQ-026 Assert rst_n=0 between clock edges mid-burst -> all outputs 0 immediately; after release, inp=50 -> outp_midi=50 and outp=0.
REQ-027 en toggled every cycle with inp changing each cycle -> only samples present on en=1 edges appear in the outp_midi sums.
